// File: rtl/gpu_cmd_dma_pkg.sv
// gpu_cmd_dma_pkg: shared CSR map, control bits, FSM states and entry geometry
package gpu_cmd_dma_pkg;
  localparam logic [1:0] CSR_BASE = 2'd0;
  localparam logic [1:0] CSR_COUNT = 2'd1;
  localparam logic [1:0] CSR_CTRL = 2'd2;
  localparam int CTRL_GO = 0;
  localparam int CTRL_ABORT = 1;
  localparam logic [31:0] ENTRY_BYTES = 32'd8;
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, FLUSH} state_t;
endpackage

// File: rtl/gpu_cmd_dma_sync_word_fifo.sv
// sync_word_fifo: single-clock FIFO with occupancy count and synchronous clear
module sync_word_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   used,
  output logic                     empty,
  output logic                     full
);
  localparam int AW = $clog2(DEPTH);
  localparam int UW = AW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_wr, do_rd;
  assign empty = used == '0;
  assign full = used == UW'(DEPTH);
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;
  assign rd_data = mem[rp];
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wp <= '0;
      rp <= '0;
      used <= '0;
    end else if (clr) begin
      wp <= '0;
      rp <= '0;
      used <= '0;
    end else begin
      if (do_wr) wp <= wp + AW'(1);
      if (do_rd) rp <= rp + AW'(1);
      used <= used + UW'(do_wr) - UW'(do_rd);
    end
  always_ff @(posedge clk)
    if (do_wr) mem[wp] <= wr_data;
endmodule

// File: rtl/gpu_cmd_dma.sv
// gpu_cmd_dma: fetches a two-word command list from memory and replays it
// onto the GPU command slave, with read credits bounded by FIFO space.
module gpu_cmd_dma
  import gpu_cmd_dma_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int MAX_OUTSTANDING = 8,
  parameter int COUNT_WIDTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  csr_address,
  input  logic        csr_write_en,
  input  logic        csr_read_en,
  input  logic [31:0] csr_write_data,
  output logic [31:0] csr_read_data,
  output logic [31:0] rd_address,
  output logic        rd_read,
  input  logic        rd_wait_request,
  input  logic [31:0] rd_readdata,
  input  logic        rd_readdatavalid,
  output logic [7:0]  gpu_address,
  output logic        gpu_write,
  output logic [31:0] gpu_write_data,
  input  logic        gpu_wait_request,
  output logic        irq
);
  localparam int UW = $clog2(FIFO_DEPTH) + 1;
  state_t state;
  logic [31:0] base, fifo_q, status;
  logic [COUNT_WIDTH-1:0] count, issued;
  logic [COUNT_WIDTH:0] words_req, words_nxt;
  logic [UW-1:0] outstanding, used;
  logic [7:0] addr_hold;
  logic phase, done, busy, live, ctrl_wr, go, abort, credit, accept, ret, push, pop, empty, full, gpu_done;
  assign busy = state != IDLE;
  assign live = state == FETCH || state == DRAIN;
  assign ctrl_wr = csr_write_en && csr_address == CSR_CTRL;
  assign go = ctrl_wr && csr_write_data[CTRL_GO];
  assign abort = ctrl_wr && csr_write_data[CTRL_ABORT];
  assign credit = ({1'b0, outstanding} + {1'b0, used}) < (UW+1)'(FIFO_DEPTH) && outstanding < UW'(MAX_OUTSTANDING);
  assign rd_read = state == FETCH && words_req < {count, 1'b0} && credit;
  assign accept = rd_read && !rd_wait_request;
  // words arriving with nothing outstanding belong to a transfer killed by reset
  assign ret = rd_readdatavalid && outstanding != '0;
  assign push = ret && live && !full;
  assign gpu_done = gpu_write && !gpu_wait_request;
  assign pop = live && !empty && (!phase || !gpu_write || !gpu_wait_request);
  assign words_nxt = words_req + (COUNT_WIDTH+1)'(1);
  assign irq = done;
  assign status = {16'(issued), 14'd0, done, busy};
  assign csr_read_data = !csr_read_en ? '0 :
                         csr_address == CSR_BASE ? base :
                         csr_address == CSR_COUNT ? 32'(count) :
                         csr_address == CSR_CTRL ? status : '0;
  sync_word_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_fifo (
    .clk(clk), .rst(rst), .clr(state == FLUSH), .wr_en(push), .wr_data(rd_readdata),
    .rd_en(pop), .rd_data(fifo_q), .used(used), .empty(empty), .full(full)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      base <= '0;
      count <= '0;
      issued <= '0;
      words_req <= '0;
      outstanding <= '0;
      rd_address <= '0;
      addr_hold <= '0;
      phase <= 1'b0;
      done <= 1'b0;
      gpu_write <= 1'b0;
      gpu_address <= '0;
      gpu_write_data <= '0;
    end else begin
      if (ctrl_wr) done <= 1'b0;
      if (csr_write_en && !busy && csr_address == CSR_BASE) base <= csr_write_data;
      if (csr_write_en && !busy && csr_address == CSR_COUNT) count <= csr_write_data[COUNT_WIDTH-1:0];
      outstanding <= outstanding + UW'(accept) - UW'(ret);
      if (accept) begin
        rd_address <= rd_address + ENTRY_BYTES / 2;
        words_req <= words_nxt;
      end
      if (pop) phase <= !phase;
      if (pop && !phase) addr_hold <= fifo_q[7:0];
      if (pop && phase) begin
        gpu_write <= 1'b1;
        gpu_address <= addr_hold;
        gpu_write_data <= fifo_q;
      end else if (gpu_done) gpu_write <= 1'b0;
      if (gpu_done) issued <= issued + COUNT_WIDTH'(1);
      case (state)
        IDLE: if (go) begin
          words_req <= '0;
          issued <= '0;
          rd_address <= base;
          phase <= 1'b0;
          if (count == '0) done <= 1'b1;
          else state <= FETCH;
        end
        FETCH: if (abort) state <= FLUSH;
          else if (accept && words_nxt == {count, 1'b0}) state <= DRAIN;
        DRAIN: if (abort) state <= FLUSH;
          else if (outstanding == '0 && empty && (!gpu_write || !gpu_wait_request)) begin
            state <= IDLE;
            done <= 1'b1;
          end
        FLUSH: begin
          phase <= 1'b0;
          if (outstanding == '0 && !gpu_write) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_gpu_cmd_dma.sv
// tb_gpu_cmd_dma: randomized memory/GPU slaves against a queue-based model of
// the command list, with per-cycle protocol checks and literal anchors.
module tb_gpu_cmd_dma;
  localparam int FD = 16, MO = 8, CW = 16;
  logic clk = 1'b0, rst = 1'b0;
  logic [1:0] csr_address = '0;
  logic csr_write_en = 1'b0, csr_read_en = 1'b0;
  logic [31:0] csr_write_data = '0, csr_read_data;
  logic [31:0] rd_address, rd_readdata = '0;
  logic rd_read, rd_wait_request = 1'b0, rd_readdatavalid = 1'b0;
  logic [7:0] gpu_address;
  logic gpu_write, gpu_wait_request = 1'b0, irq;
  logic [31:0] gpu_write_data;

  gpu_cmd_dma #(.FIFO_DEPTH(FD), .MAX_OUTSTANDING(MO), .COUNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .csr_address(csr_address), .csr_write_en(csr_write_en),
    .csr_read_en(csr_read_en), .csr_write_data(csr_write_data), .csr_read_data(csr_read_data),
    .rd_address(rd_address), .rd_read(rd_read), .rd_wait_request(rd_wait_request),
    .rd_readdata(rd_readdata), .rd_readdatavalid(rd_readdatavalid),
    .gpu_address(gpu_address), .gpu_write(gpu_write), .gpu_write_data(gpu_write_data),
    .gpu_wait_request(gpu_wait_request), .irq(irq)
  );

  always #5 clk = ~clk;

  int vec = 0, errs = 0, cyc = 0;
  typedef struct { int ret; logic [31:0] addr; } resp_t;
  resp_t resp_q[$];
  logic [31:0] exp_addr_q[$];
  logic [39:0] exp_cmd_q[$], got_q[$];
  logic [31:0] mem [logic [31:0]];
  bit run_active, flushing, exp_irq, p_rd_wait, p_gpu_wait, nv;
  bit rdw_rand, gpw_rand, gpu_hold;
  int lat_max = 1, last_ret = 0, run_done, returned;
  logic [31:0] p_addr, p_gd, nd, m_base, m_w0;
  logic [7:0] p_ga;
  logic [15:0] m_count;
  logic [39:0] m_c;
  bit m_nirq, m_busy;
  int m_infl, m_ret;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm, input logic [63:0] act);
    vec++;
    errs++;
    $display("FAIL %s: got %h with nothing expected", nm, act);
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : (a * 32'h9E3779B1) ^ 32'h1234_5678;
  endfunction

  // slave drivers: change inputs just after the active edge
  always @(posedge clk) begin
    cyc++;
    #1;
    rd_wait_request = rdw_rand && ($urandom_range(0, 2) == 0);
    gpu_wait_request = gpu_hold || (gpw_rand && ($urandom_range(0, 2) == 0));
    rd_readdatavalid = nv;
    rd_readdata = nv ? nd : $urandom;
  end

  // model and compare process, sampling mid-cycle
  always @(negedge clk) begin
    if (!rst) begin
      exp_addr_q.delete();
      exp_cmd_q.delete();
      run_active = 0;
      flushing = 0;
      exp_irq = 0;
      p_rd_wait = 0;
      p_gpu_wait = 0;
      m_base = '0;
      m_count = '0;
    end else begin
      m_busy = run_active || flushing;
      m_infl = resp_q.size() + int'(rd_readdatavalid);
      chk("irq", irq, exp_irq);
      m_nirq = exp_irq;
      if (p_rd_wait && !flushing) chk("rd_hold", {rd_read, rd_address}, {1'b1, p_addr});
      if (p_gpu_wait) chk("gpu_hold", {gpu_write, gpu_address, gpu_write_data}, {1'b1, p_ga, p_gd});
      if (!run_active) chk("rd_read_idle", rd_read, 1'b0);
      if (rd_read && !rd_wait_request) begin
        if (exp_addr_q.size() == 0) fail("rd_extra", rd_address);
        else chk("rd_address", rd_address, exp_addr_q.pop_front());
        m_ret = cyc + $urandom_range(1, lat_max);
        if (m_ret <= last_ret) m_ret = last_ret + 1;
        last_ret = m_ret;
        resp_q.push_back('{m_ret, rd_address});
      end
      chk("outstanding_max", m_infl <= MO, 1'b1);
      if (run_active) chk("fifo_bound", m_infl + returned - 2 * run_done <= FD + 3, 1'b1);
      if (run_active && rd_readdatavalid) returned++;
      if (gpu_write && !gpu_wait_request) begin
        m_c = {gpu_address, gpu_write_data};
        got_q.push_back(m_c);
        if (exp_cmd_q.size() == 0) fail("gpu_extra", m_c);
        else chk("gpu_cmd", m_c, exp_cmd_q.pop_front());
        run_done++;
        if (run_active && exp_cmd_q.size() == 0) begin
          run_active = 0;
          m_nirq = 1;
        end
      end
      if (flushing && csr_read_en && csr_address == 2'd2 && !csr_read_data[0]) begin
        flushing = 0;
        exp_cmd_q.delete();
        exp_addr_q.delete();
      end
      if (csr_write_en && !m_busy && csr_address == 2'd0) m_base = csr_write_data;
      if (csr_write_en && !m_busy && csr_address == 2'd1) m_count = csr_write_data[15:0];
      if (csr_write_en && csr_address == 2'd2) begin
        m_nirq = 0;
        if (csr_write_data[0] && !m_busy) begin
          if (m_count == 0) m_nirq = 1;
          else begin
            run_active = 1;
            run_done = 0;
            returned = 0;
            for (int i = 0; i < 2 * int'(m_count); i++) exp_addr_q.push_back(m_base + 32'(4 * i));
            for (int i = 0; i < int'(m_count); i++) begin
              m_w0 = mem_rd(m_base + 32'(8 * i));
              exp_cmd_q.push_back({m_w0[7:0], mem_rd(m_base + 32'(8 * i + 4))});
            end
          end
        end else if (csr_write_data[1] && run_active) begin
          run_active = 0;
          flushing = 1;
        end
      end
      p_rd_wait = rd_read && rd_wait_request;
      p_addr = rd_address;
      p_gpu_wait = gpu_write && gpu_wait_request;
      p_ga = gpu_address;
      p_gd = gpu_write_data;
      exp_irq = m_nirq;
    end
    // memory keeps answering even through reset
    if (resp_q.size() > 0 && resp_q[0].ret <= cyc + 1) begin
      nv = 1;
      nd = mem_rd(resp_q[0].addr);
      void'(resp_q.pop_front());
    end else nv = 0;
  end

  task automatic csr_wr(input logic [1:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    csr_address = a;
    csr_write_data = d;
    csr_write_en = 1;
    @(posedge clk);
    #1;
    csr_write_en = 0;
  endtask

  task automatic csr_rd(input logic [1:0] a, output logic [31:0] d);
    @(posedge clk);
    #1;
    csr_address = a;
    csr_read_en = 1;
    #2;
    d = csr_read_data;
    @(negedge clk);
    #1;
    csr_read_en = 0;
  endtask

  task automatic wait_run(input int budget);
    int n = 0;
    while ((run_active || exp_cmd_q.size() != 0) && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (n >= budget) fail("run_timeout", 64'(exp_cmd_q.size()));
    repeat (2) @(posedge clk);
  endtask

  task automatic run_list(input logic [31:0] b, input int n);
    csr_wr(0, b);
    csr_wr(1, 32'(n));
    csr_wr(2, 32'h1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] s, b;
    int g0, n, k;
    repeat (3) @(posedge clk);
    #3;
    chk("rst_outputs", {rd_read, rd_address, gpu_write, gpu_address, gpu_write_data, irq},
        {1'b0, 32'h0, 1'b0, 8'h0, 32'h0, 1'b0});
    csr_rd(2, s);
    chk("rst_status", s, 32'h0);
    @(posedge clk);
    #1 rst = 1;

    mem[32'h1000] = 32'h01; mem[32'h1004] = 32'h2000;
    mem[32'h1008] = 32'h02; mem[32'h100c] = 32'h40;
    mem[32'h1010] = 32'h00; mem[32'h1014] = 32'h0;
    g0 = got_q.size();
    run_list(32'h1000, 3);
    chk("first_rd", {rd_read, rd_address}, {1'b1, 32'h1000});
    wait_run(500);
    chk("t1_n", 64'(got_q.size() - g0), 64'd3);
    if (got_q.size() >= g0 + 3) begin
      chk("t1_cmd0", got_q[g0], {8'h01, 32'h2000});
      chk("t1_cmd1", got_q[g0 + 1], {8'h02, 32'h40});
      chk("t1_cmd2", got_q[g0 + 2], {8'h00, 32'h0});
    end
    chk("t1_irq", irq, 1'b1);
    csr_rd(2, s);
    chk("t1_status", s, 32'h0003_0002);

    csr_wr(1, 0);
    csr_wr(2, 32'h1);
    chk("zero_done", irq, 1'b1);
    csr_rd(2, s);
    chk("zero_status", s, 32'h0000_0002);
    csr_wr(2, 32'h0);
    chk("irq_clear", irq, 1'b0);

    rdw_rand = 1; gpw_rand = 1; lat_max = 10;
    for (int r = 0; r < 4; r++) begin
      b = (r == 3) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
      n = (r == 3) ? 4 : $urandom_range(1, 12);
      run_list(b, n);
      if (r == 1) csr_wr(0, 32'hDEAD_0000);
      wait_run(2000);
      csr_rd(2, s);
      chk("rand_status", s, {16'(n), 16'h0002});
      if (r == 1) begin
        csr_rd(0, s);
        chk("base_locked", s, b);
      end
    end

    rdw_rand = 0; gpw_rand = 0; lat_max = 3;
    run_list(32'h4000, 16);
    gpu_hold = 1;
    repeat (50) @(posedge clk);
    gpu_hold = 0;
    wait_run(2000);
    csr_rd(2, s);
    chk("hold_status", s, 32'h0010_0002);

    rdw_rand = 1; gpw_rand = 1; lat_max = 5;
    run_list(32'h8000, 20);
    k = 0;
    while (run_done < 5 && k < 1000) begin
      @(posedge clk);
      k++;
    end
    if (k >= 1000) fail("abort_wait", 64'(run_done));
    csr_wr(2, 32'h2);
    k = 0;
    s = 32'h1;
    while (s[0] && k < 300) begin
      csr_rd(2, s);
      k++;
    end
    chk("abort_busy", s[0], 1'b0);
    chk("abort_done", s[1], 1'b0);
    chk("abort_outst", 64'(resp_q.size()), 64'd0);
    chk("abort_irq", irq, 1'b0);
    run_list(32'h9000, 2);
    wait_run(500);
    csr_rd(2, s);
    chk("post_abort_status", s, 32'h0002_0002);

    rdw_rand = 0; gpw_rand = 0; lat_max = 10;
    run_list(32'hA000, 20);
    k = 0;
    while (resp_q.size() < 4 && k < 50) begin
      @(posedge clk);
      k++;
    end
    if (k >= 50) fail("rst_wait", 64'(resp_q.size()));
    #3 rst = 0;
    #1;
    chk("async_rst", {rd_read, rd_address, gpu_write, gpu_address, gpu_write_data, irq},
        {1'b0, 32'h0, 1'b0, 8'h0, 32'h0, 1'b0});
    repeat (2) @(posedge clk);
    #1 rst = 1;
    repeat (30) begin
      @(negedge clk);
      chk("post_rst_gpu", gpu_write, 1'b0);
    end
    csr_rd(2, s);
    chk("post_rst_status", s, 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule

// File: doc/gpu_cmd_dma.md
# gpu_cmd_dma

Command-list fetch engine upstream of the GPU core's command slave. The CPU writes a list base address and entry count, then sets a go bit. The block reads the list from SDRAM with a pipelined Avalon read master and assembles each two-word entry into one command. It replays each command onto the GPU core's Avalon command slave as `{address, data}`, honouring that slave's wait_request back-pressure. This offloads per-command CPU writes during tile rendering.

## Interface
Parameters:
- `FIFO_DEPTH`, 16: word FIFO entries (power of two, ≥ 2·`MAX_OUTSTANDING`)
- `MAX_OUTSTANDING`, 8: read requests in flight, max
- `COUNT_WIDTH`, 16: width of entry count

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: sole clock, same domain as the GPU core's `clk`
- `rst` in 1: asynchronous, active-low reset
- `csr_address` in 2: 0 = base addr, 1 = entry count, 2 = control/status
- `csr_write_en` in 1; `csr_read_en` in 1; `csr_write_data` in 32; `csr_read_data` out 32 (combinational)
- `rd_address` out 32: byte address, word aligned
- `rd_read` out 1; `rd_wait_request` in 1; `rd_readdata` in 32; `rd_readdatavalid` in 1
- `gpu_address` out 8; `gpu_write` out 1; `gpu_write_data` out 32; `gpu_wait_request` in 1
- `irq` out 1: level, set on done, cleared by a write to control

## Operation
- Entry format: word0[7:0] = GPU slave address, word0[31:8] ignored; word1 = data. Entry i sits at base + 8·i.
- Control write (addr 2): bit0 go, bit1 abort, any write clears `done`/`irq`. Status read: bit0 busy, bit1 done, bits[31:16] entries issued.
- go is ignored while busy. Base/count writes while busy are ignored.
- FSM states:
  - IDLE: go with count ≠ 0 → FETCH. go with count = 0 → done set, stays IDLE.
  - FETCH: issue reads until 2·count words are requested → DRAIN.
  - DRAIN: wait until outstanding = 0, FIFO empty and no GPU write pending → IDLE, done set.
  - abort in FETCH/DRAIN → FLUSH.
  - FLUSH: stop issuing reads; discard returning words; finish any GPU write already asserted; when outstanding = 0 → IDLE with done = 0.
- Credit rule: `rd_read` is asserted only when `outstanding + fifo_used < FIFO_DEPTH` and `outstanding < MAX_OUTSTANDING`. The FIFO can never overflow.
- Pairing: a phase bit toggles per FIFO pop. word0 goes into an address holding register. Popping word1 loads `gpu_address`/`gpu_write_data` and asserts `gpu_write`.
- Address counter is 32 bits and wraps modulo 2^32 without error. The word counter is `COUNT_WIDTH+1` bits.

## Timing
- Reset values: `rd_read`=0, `rd_address`=0, `gpu_write`=0, `gpu_address`=0, `gpu_write_data`=0, `irq`=0, FSM = IDLE, counters = 0, FIFO empty.
- Reset mid-transfer: all state clears immediately. Read data still returning after reset is ignored.
- `rd_read`/`rd_address` are held stable while `rd_wait_request`=1. A request is accepted on a cycle with `rd_read & !rd_wait_request`. Outstanding increments on accept and decrements on `rd_readdatavalid`; both in the same cycle leave it unchanged.
- First `rd_read`: the cycle after go is sampled.
- FIFO is registered with write-then-read latency 1. A returned word0/word1 pair yields `gpu_write` ≥ 2 cycles after word1 is valid.
- `gpu_*` outputs are held stable while `gpu_wait_request`=1. The GPU write completes on `gpu_write & !gpu_wait_request`. The next command may be presented in the following cycle, which gives a sustained rate of one command per 2 clocks (one FIFO pop per cycle).
- done/`irq` rise the cycle after the last GPU write completes.

## Structure
- Shared package `gpu_cmd_dma_pkg`: CSR offsets, control/status bit positions, FSM state enum (IDLE, FETCH, DRAIN, FLUSH), entry size constant (8 bytes).
- One sub-module, `sync_word_fifo`: single-clock FIFO parameterised on depth and width, with `used` count output and empty/full flags.

## Test plan
- Count = 3 at base 0x1000, memory holds {0x01,0x2000}, {0x02,0x0040}, {0x00,0x0}. Response: `rd_address` 0x1000..0x1014 in order; GPU writes (0x01,0x2000), (0x02,0x40), (0x00,0x0); done=1; `irq`=1; status[31:16]=3.
- `gpu_wait_request` held high for 50 cycles during a 16-entry list. Response: ≤ FIFO_DEPTH − outstanding words buffered, no overflow, `gpu_*` stable throughout, all 16 commands delivered in order.
- Random `rd_wait_request` plus `rd_readdatavalid` latency of 1–10 cycles. Response: outstanding never exceeds 8; data order is preserved.
- go with count = 0. Response: no `rd_read`, done=1 the next cycle.
- Abort after 5 of 20 entries. Response: reads stop within 1 cycle; no partial pair is emitted; busy=0 once outstanding=0; done=0.
- `rst` asserted low during FETCH with 4 reads outstanding. Response: all outputs take reset values asynchronously; late `rd_readdatavalid` words produce no `gpu_write`.
